instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the fetched instruction and its PC+4 to the IF/ID pipeline register. It is the producer side of the IF/ID interface. It honours the same stall signal, IF_ID_Write, that holds the IF/ID register, and it accepts branch/jump redirects from later stages. When it has no instruction ready it drives a bubble.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0000, instruction word driven when no valid instruction is present

- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- IF_ID_Write  in  1  stall: 1 = IF/ID holds this cycle (no consume), 0 = IF/ID latches this cycle
- PC_Src  in  1  redirect request (taken branch/jump), sampled at the edge
- PC_Target  in  32  redirect address; word aligned
- imem_req  out  1  read request
- imem_addr  out  32  read address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  read data valid this cycle; may assert in the first req cycle (zero-wait)
- imem_rdata  in  32  instruction word, sampled at the edge where imem_ack=1
- IF_INSTR  out  32  buffered instruction, or NOP when IF_Valid=0
- IF_PC  out  32  fetch address + 4 of IF_INSTR; 0 when IF_Valid=0
- IF_Valid  out  1  buffer holds a real instruction

## Operation
- State: pc (next fetch address), a one-entry buffer {buf_instr, buf_pc4, buf_valid}, pending flag, and FSM {FETCH, DROP}.
- consume = buf_valid & !IF_ID_Write.
- imem_req = pending | (state==FETCH & (!buf_valid | consume)). imem_addr = pc in FETCH, drop_addr in DROP.
- pending: set at an edge with imem_req=1 & imem_ack=0; cleared on ack. While pending, req and addr are held regardless of stall. The buffer is always empty while pending.
- Ack in FETCH with no redirect:
  - buf <= {imem_rdata, pc+4, 1}
  - pc <= pc+4 (32-bit wrap; 0xFFFF_FFFC+4 = 0)
- Consume without refill: buf_valid <= 0.
- Redirect (PC_Src=1) has priority over stall and ack:
  - buf_valid <= 0
  - pc <= PC_Target
  - a same-edge ack is discarded
  - If a request is pending and not acked this edge: drop_addr <= current addr, state <= DROP.
- DROP: req held at drop_addr until ack. Data is discarded, then state <= FETCH. A further redirect in DROP only updates pc.
- Outputs are combinational from the buffer. IF_ID_Write never alters buffer contents except through consume.

## Timing
- Reset (edge with reset=1) sets:
  - pc=RESET_PC, buf_valid=0, pending=0, state=FETCH
  - IF_INSTR=NOP, IF_PC=0, IF_Valid=0
  - imem_req=0 while reset is high
- First imem_req=1 in the first cycle after reset deasserts. Reset overrides pending: the in-flight request is abandoned, and any later stale ack is ignored because req=0 is required for acceptance.
- Fetch latency: an instruction becomes visible on IF_* the cycle after its ack edge. With a zero-wait memory and no stall, throughput is 1 instruction/cycle.
- Redirect: the bubble is visible the cycle after the PC_Src edge.
  - No pending request: first fetch of PC_Target is in that same cycle.
  - Pending request: first fetch of PC_Target is in the cycle after the dropped ack.
- Simultaneous consume + ack: the buffer refills on the same edge, with no bubble.

## Test plan
- Reset, zero-wait memory (ack whenever req), no stall -> imem_addr 0,4,8,... on consecutive cycles. IF_PC 4,8,12 starting one cycle after first req. IF_Valid continuous.
- Memory with 2 wait cycles -> each address is held 3 cycles. IF_Valid=0 with IF_INSTR=NOP for 2 cycles between instructions. IF_PC steps by 4.
- Zero-wait memory, IF_ID_Write=1 for 3 cycles with buffer full -> IF_INSTR/IF_PC held, imem_req=0, pc unchanged. Fetching resumes the cycle IF_ID_Write drops.
- PC_Src=1, PC_Target=0x100 with buffer full and no pending -> next cycle IF_Valid=0 and imem_addr=0x100. The following cycle gives IF_PC=0x104.
- 3-wait memory, redirect to 0x200 one cycle after req at 0x8 -> imem_addr stays 0x8 until ack. That data never appears on IF_*. Next req addr is 0x200.
- PC_Src=1 and IF_ID_Write=1 on the same edge with an ack -> redirect wins: buffer flushed, ack data dropped, pc=target.
- Reset asserted while pending -> imem_req=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. Owns the program counter, reads instruction words
// from instruction memory over a req/ack handshake and presents the fetched
// word plus its PC+4 to the IF/ID pipeline register through a one-entry
// buffer. A bubble (NOP, PC 0, valid 0) is shown whenever the buffer is empty.
//
// Ports
//   clock        in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   IF_ID_Write  in   1 = IF/ID holds this cycle, 0 = IF/ID latches
//   PC_Src       in   redirect request (taken branch / jump)
//   PC_Target    in   redirect address (word aligned)
//   imem_req     out  instruction memory read request
//   imem_addr    out  read address, held while a request is outstanding
//   imem_ack     in   read data valid this cycle (zero-wait allowed)
//   imem_rdata   in   instruction word, sampled on an acked edge
//   IF_INSTR     out  buffered instruction, or NOP when IF_Valid=0
//   IF_PC        out  fetch address + 4 of IF_INSTR, 0 when IF_Valid=0
//   IF_Valid     out  buffer holds a real instruction
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IF_ID_Write,
   input  logic        PC_Src,
   input  logic [31:0] PC_Target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_INSTR,
   output logic [31:0] IF_PC,
   output logic        IF_Valid
);

   typedef enum logic {FETCH, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        buf_valid_q, buf_valid_d;
   logic        pending_q, pending_d;

   logic        consume;
   logic        ack;

   // Handshake: a request outstanding to memory is held (address and req)
   // until acked, independent of stall. Reset masks req so that a stale ack
   // arriving after reset is never accepted.
   always_comb begin
      consume   = buf_valid_q & ~IF_ID_Write;
      imem_req  = ~reset & (pending_q |
                  ((state_q == FETCH) & (~buf_valid_q | consume)));
      imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
      ack       = imem_req & imem_ack;
   end

   // Next-state: redirect beats stall and ack.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;
      buf_valid_d = buf_valid_q;
      drop_addr_d = drop_addr_q;
      pending_d   = pending_q;

      if (PC_Src) begin
         buf_valid_d = 1'b0;
         pc_d        = PC_Target;
         if ((state_q == FETCH) && imem_req && !imem_ack) begin
            // Request in flight to the old path: keep it alive until memory
            // answers, then throw the data away.
            drop_addr_d = imem_addr;
            state_d     = DROP;
            pending_d   = 1'b1;
         end else if (ack) begin
            // Same-edge ack belongs to the old path and is discarded.
            pending_d = 1'b0;
            state_d   = FETCH;
         end
      end else if (state_q == DROP) begin
         if (ack) begin
            pending_d = 1'b0;
            state_d   = FETCH;
         end
      end else begin
         if (ack) begin
            // Refill covers the simultaneous consume + ack case with no bubble.
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_q + 32'd4;
            buf_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            pending_d   = 1'b0;
         end else begin
            if (consume) begin
               buf_valid_d = 1'b0;
            end
            if (imem_req) begin
               pending_d = 1'b1;
            end
         end
      end
   end

   // Control state: reset applies here only.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         buf_valid_q <= 1'b0;
         pending_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_valid_q <= buf_valid_d;
         pending_q   <= pending_d;
      end
   end

   // Data state: qualified by buf_valid_q / state_q, so no reset needed.
   always_ff @(posedge clock) begin
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      drop_addr_q <= drop_addr_d;
   end

   always_comb begin
      IF_Valid = buf_valid_q;
      IF_INSTR = buf_valid_q ? buf_instr_q : NOP;
      IF_PC    = buf_valid_q ? buf_pc4_q : 32'h0000_0000;
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clock;
   logic        reset;
   logic        IF_ID_Write;
   logic        PC_Src;
   logic [31:0] PC_Target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_INSTR;
   logic [31:0] IF_PC;
   logic        IF_Valid;

   int errors = 0;
   int checks = 0;
   int waits  = 0;
   int wcnt   = 0;

   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_ins_q[$];

   instr_fetch dut (
      .clock      (clock),
      .reset      (reset),
      .IF_ID_Write(IF_ID_Write),
      .PC_Src     (PC_Src),
      .PC_Target  (PC_Target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .IF_INSTR   (IF_INSTR),
      .IF_PC      (IF_PC),
      .IF_Valid   (IF_Valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected IF/ID deliveries, in order.
   task automatic push(input logic [31:0] addr);
      exp_pc_q.push_back(addr + 32'd4);
      exp_ins_q.push_back(memword(addr));
   endtask

   // Memory model: acks after 'waits' cycles of a held request.
   always @(negedge clock) begin
      if (imem_req && (wcnt >= waits)) begin
         imem_ack   = 1'b1;
         imem_rdata = memword(imem_addr);
      end else begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
      end
   end

   always @(posedge clock) begin
      if (imem_req && !imem_ack) wcnt = wcnt + 1;
      else wcnt = 0;
   end

   // Monitor: the IF/ID register takes an instruction on any edge where it
   // is valid, not stalled, not flushed by a redirect and not in reset.
   always @(negedge clock) begin
      logic [31:0] epc, eins;
      if (!reset && !PC_Src && !IF_ID_Write && IF_Valid) begin
         if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery: got IF_PC=%h IF_INSTR=%h, want none", IF_PC, IF_INSTR);
         end else begin
            epc  = exp_pc_q.pop_front();
            eins = exp_ins_q.pop_front();
            check("deliver_pc", IF_PC, epc);
            check("deliver_instr", IF_INSTR, eins);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   task automatic reset_dut();
      next_cycle();
      reset = 1'b1; PC_Src = 1'b0; IF_ID_Write = 1'b0;
      settle();
      check("sb_drained", exp_pc_q.size(), 0);
      check("rst_req", imem_req, 0);
      next_cycle();
      settle();
      check("rst_req2", imem_req, 0);
      check("rst_valid", IF_Valid, 0);
      check("rst_instr", IF_INSTR, 32'h0);
      check("rst_pc", IF_PC, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; IF_ID_Write = 1'b0; PC_Src = 1'b0; PC_Target = 32'h0;
      imem_ack = 1'b0; imem_rdata = 32'h0;

      // A: zero-wait streaming, then a 3-cycle stall
      waits = 0;
      reset_dut();
      for (int a = 0; a <= 24; a += 4) push(a);
      for (int c = 0; c <= 10; c++) begin
         next_cycle();
         reset = 1'b0;
         IF_ID_Write = (c >= 6 && c <= 8);
         settle();
         if (c <= 5) begin
            check("A_req", imem_req, 1);
            check("A_addr", imem_addr, 4 * c);
            if (c >= 1) check("A_valid", IF_Valid, 1);
         end else if (c <= 8) begin
            check("A_stall_req", imem_req, 0);
            check("A_stall_pc", IF_PC, 32'd24);
            check("A_stall_instr", IF_INSTR, memword(32'd20));
         end else if (c == 9) begin
            check("A_resume_req", imem_req, 1);
            check("A_resume_addr", imem_addr, 32'd24);
         end else begin
            check("A_after_pc", IF_PC, 32'd28);
            check("A_after_addr", imem_addr, 32'd28);
         end
      end

      // B: redirect with buffer full, nothing pending
      reset_dut();
      push(32'h0); push(32'h4); push(32'h100); push(32'h104);
      for (int c = 0; c <= 6; c++) begin
         next_cycle();
         reset = 1'b0;
         PC_Src = (c == 3);
         PC_Target = 32'h100;
         settle();
         if (c == 4) begin
            check("B_bubble", IF_Valid, 0);
            check("B_bubble_instr", IF_INSTR, 32'h0);
            check("B_req", imem_req, 1);
            check("B_addr", imem_addr, 32'h100);
         end
         if (c == 5) check("B_pc", IF_PC, 32'h104);
      end

      // C: 2 wait cycles per access
      waits = 2;
      reset_dut();
      push(32'h0); push(32'h4); push(32'h8);
      for (int c = 0; c <= 9; c++) begin
         next_cycle();
         reset = 1'b0;
         PC_Src = 1'b0;
         settle();
         check("C_req", imem_req, 1);
         check("C_addr", imem_addr, 4 * (c / 3));
         check("C_valid", IF_Valid, (c % 3 == 0 && c > 0));
         if (!(c % 3 == 0 && c > 0)) begin
            check("C_nop", IF_INSTR, 32'h0);
            check("C_pc0", IF_PC, 32'h0);
         end
      end

      // D: 3 wait cycles, redirect while a request is outstanding
      waits = 3;
      reset_dut();
      push(32'h0); push(32'h4); push(32'h200);
      for (int c = 0; c <= 16; c++) begin
         next_cycle();
         reset = 1'b0;
         PC_Src = (c == 9);
         PC_Target = 32'h200;
         settle();
         if (c >= 8 && c <= 11) begin
            check("D_hold_req", imem_req, 1);
            check("D_hold_addr", imem_addr, 32'h8);
         end
         if (c >= 10 && c <= 12) check("D_bubble", IF_Valid, 0);
         if (c >= 12 && c <= 15) check("D_new_addr", imem_addr, 32'h200);
         if (c == 16) check("D_pc", IF_PC, 32'h204);
      end

      // E: redirect + stall + ack on the same edge
      waits = 1;
      reset_dut();
      push(32'h0); push(32'h300);
      for (int c = 0; c <= 6; c++) begin
         next_cycle();
         reset = 1'b0;
         PC_Src = (c == 3);
         IF_ID_Write = (c == 3);
         PC_Target = 32'h300;
         settle();
         if (c == 3) begin
            check("E_req_held", imem_req, 1);
            check("E_addr_held", imem_addr, 32'h4);
         end
         if (c == 4) begin
            check("E_flushed", IF_Valid, 0);
            check("E_addr", imem_addr, 32'h300);
         end
         if (c == 6) check("E_pc", IF_PC, 32'h304);
      end

      // F: reset while a request is pending
      waits = 3;
      reset_dut();
      for (int c = 0; c <= 1; c++) begin
         next_cycle();
         reset = 1'b0; PC_Src = 1'b0; IF_ID_Write = 1'b0;
         settle();
         check("F_pend_req", imem_req, 1);
      end
      next_cycle();
      reset = 1'b1;
      settle();
      check("F_rst_req", imem_req, 0);
      next_cycle();
      settle();
      push(32'h0);
      for (int c = 0; c <= 4; c++) begin
         next_cycle();
         reset = 1'b0;
         settle();
         if (c == 0) begin
            check("F_restart_req", imem_req, 1);
            check("F_restart_addr", imem_addr, 32'h0);
         end
         if (c == 4) check("F_pc", IF_PC, 32'h4);
      end

      // G: PC wrap-around
      waits = 0;
      reset_dut();
      push(32'hFFFF_FFF8); push(32'hFFFF_FFFC); push(32'h0);
      for (int c = 0; c <= 5; c++) begin
         next_cycle();
         reset = 1'b0;
         PC_Src = (c == 1);
         PC_Target = 32'hFFFF_FFF8;
         settle();
         if (c == 3) check("G_pc_fffc", IF_PC, 32'hFFFF_FFFC);
         if (c == 4) begin
            check("G_wrap_pc", IF_PC, 32'h0);
            check("G_wrap_valid", IF_Valid, 1);
            check("G_wrap_addr", imem_addr, 32'h0);
         end
      end

      next_cycle();
      reset = 1'b1; PC_Src = 1'b0;
      settle();
      check("final_sb_drained", exp_pc_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
